hazard_forwarding_unit: RTL
===========================

// Module: hazard_forwarding_unit
// PURPOSE
//  Next-generation hazard and forwarding controller for the 5-stage MIPS pipeline. Tracks the EX-stage
//  instruction internally (shadow of ID/EX), generates per-operand EX forwarding selects from MEM and WB,
//  and detects load-use hazards in ID with a multi-cycle stall FSM. Supports NUM_SRC operands per instruction.
// PARAMETERS
//  REG_ADDR_WIDTH  5   register address width
//  NUM_SRC         2   source operands per instruction (rs, rt, ...)
//  LOAD_LAT        1   stall cycles per load-use hazard, >=1
//  CNT_WIDTH       32  width of stall counter (DFU_STALL_CNT_EN only)
// PORTS
//  clk            in   1                        clock
//  rst            in   1                        synchronous reset, active-high
//  id_valid       in   1                        ID holds a real instruction
//  id_src         in   NUM_SRC*REG_ADDR_WIDTH   ID source addrs, operand i at [i*RAW +: RAW]
//  id_src_used    in   NUM_SRC                  operand i is read by the instruction
//  id_writeReg    in   1                        ID instruction writes a register
//  id_regToWrite  in   REG_ADDR_WIDTH           ID destination
//  id_isLoad      in   1                        ID instruction is a load
//  flush          in   1                        squash ID/EX (branch/jump redirect)
//  mem_writeReg   in   1                        MEM stage writes a register
//  mem_regToWrite in   REG_ADDR_WIDTH           MEM destination
//  wb_writeReg    in   1                        WB stage writes a register
//  wb_regToWrite  in   REG_ADDR_WIDTH           WB destination
//  fwd_sel        out  NUM_SRC*2                EX operand select: 00 regfile, 01 MEM, 10 WB, 11 unused
//  stall          out  1                        hold PC and IF/ID
//  bubble         out  1                        insert NOP into ID/EX this cycle
//  stall_cnt      out  CNT_WIDTH                total stall cycles (DFU_STALL_CNT_EN only)
// BEHAVIOUR
//  - Reset: FSM IDLE, EX shadow invalid (src_used=0, writeReg=0, isLoad=0), stall=0, bubble=0, fwd_sel=0, stall_cnt=0.
//  - EX shadow: each clk, if flush or bubble -> cleared as at reset; else if id_valid -> loads id_* fields; else cleared.
//  - fwd_sel[i] combinational from EX shadow + MEM/WB inputs (zero cycle latency):
//    MEM if ex_src_used[i] & mem_writeReg & mem_regToWrite==ex_src[i] & ex_src[i]!=0;
//    else WB under the same rule with wb_*; else 00. MEM wins when MEM and WB both match.
//  - Register 0 never forwards and never causes a hazard.
//  - Load-use hit: id_valid & id_src_used[i] & ex_isLoad & ex_writeReg & ex_regToWrite==id_src[i]!=0 for any i.
//  - FSM IDLE: on hit and !flush -> stall=1, bubble=1 same cycle; if LOAD_LAT>1 go STALL with cnt=LOAD_LAT-1.
//    With LOAD_LAT=1 remain IDLE (the bubble clears ex_isLoad, so no re-trigger).
//  - FSM STALL: stall=1, bubble=1; cnt decrements; cnt==1 -> IDLE next cycle. Exactly LOAD_LAT stall cycles total.
//    No new hit is evaluated in STALL (EX holds a bubble).
//  - flush in any state: FSM -> IDLE, cnt=0, stall=0, bubble=0 that cycle; flush has priority over hit.
//  - rst mid-stall: all state returns to reset values next edge; outputs 0 from then on.
//  - cnt width is clog2(LOAD_LAT+1); LOAD_LAT<1 is an elaboration error.
// CONFIGURATION
//  DFU_STALL_CNT_EN defined: stall_cnt increments by 1 on every cycle with stall=1, saturates at all-ones,
//    cleared by rst only. Undefined: stall_cnt port absent, no counter logic.
// STRUCTURE
//  Package dfu_pkg: fwd_sel_t localparams FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10; state_t {IDLE, STALL}.
//  Sub-module dfu_operand_match: one source addr/used vs MEM and WB -> 2-bit select and zero-reg gate;
//    generated NUM_SRC times for fwd_sel. Load-use compare, FSM and EX shadow live in the top.
// TESTING
//  1 EX add $3, MEM writes $3, WB writes $3 -> fwd_sel[0]=01 (MEM priority); MEM off -> 10.
//  2 lw $5 in EX shadow, ID reads $5 as rt, LOAD_LAT=1 -> stall=1, bubble=1 for 1 cycle; next cycle stall=0.
//  3 Same with LOAD_LAT=3 -> stall high exactly 3 cycles, FSM IDLE->STALL->STALL->IDLE.
//  4 lw $0 in EX, ID reads $0; MEM writes $0 -> no stall, fwd_sel=00.
//  5 Load-use hit with flush=1 same cycle -> stall=0, EX shadow cleared; rst in 2nd stall cycle -> all outputs 0.
//  6 DFU_STALL_CNT_EN, two LOAD_LAT=2 hazards -> stall_cnt=4; CNT_WIDTH=2 forced 5 stalls -> holds 3.

Source files
------------

// File: rtl/dfu_pkg.sv
// Shared types for the hazard/forwarding unit: EX operand select codes and stall FSM states.
package dfu_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/dfu_operand_match.sv
// One EX source operand against the MEM and WB destinations; MEM is younger so it wins.
module dfu_operand_match
  import dfu_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] i_src,
  input  logic                      i_used,
  input  logic                      i_mem_we,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd,
  input  logic                      i_wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd,
  output fwd_sel_t                  o_sel
);

  logic w_live;

  // $0 is hardwired to zero, so it never needs a bypass.
  assign w_live = i_used & (i_src != {REG_ADDR_WIDTH{1'b0}});

  always_comb begin
    o_sel = FWD_REG;
    if (w_live && i_mem_we && (i_mem_rd == i_src)) begin
      o_sel = FWD_MEM;
    end else if (w_live && i_wb_we && (i_wb_rd == i_src)) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// EX forwarding selects plus load-use stall FSM for the 5-stage pipeline.
// Optional stall-cycle counter enabled by defining DFU_STALL_CNT_EN.
module hazard_forwarding_unit
  import dfu_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2,
  parameter int LOAD_LAT       = 1
`ifdef DFU_STALL_CNT_EN
  ,
  parameter int CNT_WIDTH      = 32
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] id_src,
  input  logic [NUM_SRC-1:0]                id_src_used,
  input  logic                              id_writeReg,
  input  logic [REG_ADDR_WIDTH-1:0]         id_regToWrite,
  input  logic                              id_isLoad,
  input  logic                              flush,
  input  logic                              mem_writeReg,
  input  logic [REG_ADDR_WIDTH-1:0]         mem_regToWrite,
  input  logic                              wb_writeReg,
  input  logic [REG_ADDR_WIDTH-1:0]         wb_regToWrite,
  output logic [NUM_SRC*2-1:0]              fwd_sel,
  output logic                              stall,
  output logic                              bubble
`ifdef DFU_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]              stall_cnt
`endif
);

  localparam int RAW = REG_ADDR_WIDTH;
  localparam int CW  = $clog2(LOAD_LAT + 1);

  if (LOAD_LAT < 1) begin : g_bad_load_lat
    $error("hazard_forwarding_unit: LOAD_LAT must be >= 1");
  end

  state_t                     r_state;
  logic [CW-1:0]              r_cnt;
  logic [NUM_SRC*RAW-1:0]     r_ex_src;
  logic [NUM_SRC-1:0]         r_ex_src_used;
  logic                       r_ex_writeReg;
  logic [RAW-1:0]             r_ex_regToWrite;
  logic                       r_ex_isLoad;
  logic                       w_hit;
  logic                       w_stall;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_op
    fwd_sel_t w_sel;
    dfu_operand_match #(.REG_ADDR_WIDTH(RAW)) u_match (
      .i_src    (r_ex_src[g*RAW +: RAW]),
      .i_used   (r_ex_src_used[g]),
      .i_mem_we (mem_writeReg),
      .i_mem_rd (mem_regToWrite),
      .i_wb_we  (wb_writeReg),
      .i_wb_rd  (wb_regToWrite),
      .o_sel    (w_sel)
    );
    assign fwd_sel[g*2 +: 2] = w_sel;
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_hit = w_hit | (id_valid & id_src_used[i] & r_ex_isLoad & r_ex_writeReg &
                       (r_ex_regToWrite == id_src[i*RAW +: RAW]) &
                       (id_src[i*RAW +: RAW] != {RAW{1'b0}}));
    end
  end

  // A redirect kills the dependent instruction, so flush overrides any stall.
  always_comb begin
    w_stall = 1'b0;
    if (flush) begin
      w_stall = 1'b0;
    end else begin
      case (r_state)
        IDLE:    w_stall = w_hit;
        STALL:   w_stall = 1'b1;
        default: w_stall = 1'b0;
      endcase
    end
  end

  assign stall  = w_stall;
  assign bubble = w_stall;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit && (LOAD_LAT > 1)) begin
            r_state <= STALL;
            r_cnt   <= CW'(LOAD_LAT - 1);
          end else begin
            r_state <= IDLE;
            r_cnt   <= {CW{1'b0}};
          end
        end
        STALL: begin
          if (r_cnt <= CW'(1)) begin
            r_state <= IDLE;
            r_cnt   <= {CW{1'b0}};
          end else begin
            r_state <= STALL;
            r_cnt   <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Shadow of ID/EX: a bubble or squash leaves EX holding an invalid slot.
  always_ff @(posedge clk) begin
    if (rst || flush || w_stall || !id_valid) begin
      r_ex_src        <= {(NUM_SRC*RAW){1'b0}};
      r_ex_src_used   <= {NUM_SRC{1'b0}};
      r_ex_writeReg   <= 1'b0;
      r_ex_regToWrite <= {RAW{1'b0}};
      r_ex_isLoad     <= 1'b0;
    end else begin
      r_ex_src        <= id_src;
      r_ex_src_used   <= id_src_used;
      r_ex_writeReg   <= id_writeReg;
      r_ex_regToWrite <= id_regToWrite;
      r_ex_isLoad     <= id_isLoad;
    end
  end

`ifdef DFU_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= {CNT_WIDTH{1'b0}};
    end else if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
